lu_row_server: RTL and testbench

//  Responder/memory side of the LU engine row protocol. Holds the SIZE-row complex matrix and services the engine's row reads and row write-backs.

---
 rtl/lu_row_server_pkg.sv | 45 ++++
 rtl/lu_row_server_bank.sv | 48 ++++
 rtl/lu_row_server.sv | 236 +++++++++++++++++++++++
 tb/tb_lu_row_server.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lu_row_server_pkg.sv
// lu_row_server_pkg
//   Shared constants, types and helpers for the LU row server slice.
//   - LU_SIZE / LU_WIDTH : default matrix order and bits per real/imag part
//   - addr_w()/row_w()   : derive row-index width and packed row width
//   - cplx_t             : one complex element, {imag, real}
//   - row_sel_e          : host readback source select
//   - srv_state_e        : symbolic names for the server operating modes
package lu_row_server_pkg;

  localparam int LU_SIZE  = 16;
  localparam int LU_WIDTH = 64;

  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int row_w(input int size, input int width);
    return size * 2 * width;
  endfunction

  typedef struct packed {
    logic [LU_WIDTH-1:0] im;
    logic [LU_WIDTH-1:0] re;
  } cplx_t;

  typedef enum logic [1:0] {
    SEL_MAT  = 2'd0,
    SEL_L    = 2'd1,
    SEL_U    = 2'd2,
    SEL_RSVD = 2'd3
  } row_sel_e;

  typedef enum logic [1:0] {
    SRV_IDLE = 2'd0,
    SRV_RUN  = 2'd1,
    SRV_DONE = 2'd2
  } srv_state_e;

  // Element j of a packed row, laid out as {imag, real} at [j*2*WIDTH +: 2*WIDTH].
  function automatic cplx_t row_elem(input logic [row_w(LU_SIZE, LU_WIDTH)-1:0] row,
                                     input int j);
    return row[j*2*LU_WIDTH +: 2*LU_WIDTH];
  endfunction

endpackage

// File: rtl/lu_row_server_bank.sv
// lu_row_server_bank
//   DEPTH x ROW_W row storage with one write port and one registered read port.
//   Contents are never reset. When WRITE_FIRST is set, a read and a write to the
//   same row in the same cycle return the incoming write data.
// Ports
//   clk_i    in   1      clock
//   we_i     in   1      write enable
//   waddr_i  in   AW     write row index
//   wdata_i  in   ROW_W  write data
//   re_i     in   1      read enable (output register only updates when set)
//   raddr_i  in   AW     read row index
//   rdata_o  out  ROW_W  registered read data
module lu_row_server_bank
  import lu_row_server_pkg::*;
#(
  parameter int DEPTH       = LU_SIZE,
  parameter int ROW_W       = row_w(LU_SIZE, LU_WIDTH),
  parameter bit WRITE_FIRST = 1'b0,
  localparam int AW         = addr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [ROW_W-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [ROW_W-1:0] rdata_o
);

  logic [ROW_W-1:0] mem [DEPTH];
  logic [ROW_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      if (WRITE_FIRST && we_i && (waddr_i == raddr_i)) begin
        rdata_q <= wdata_i;
      end else begin
        rdata_q <= mem[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lu_row_server.sv
// lu_row_server
//   Memory/responder side of the LU engine row protocol. Holds the matrix (M),
//   captures the engine's L columns and U rows into two banks, and gives the
//   host load, start, flush, clear and readback control.
//   Build option: define LU_ROW_SERVER_BYPASS_EN to make a same-cycle engine
//   read and write-back to one row return the new row (write-first); otherwise
//   the old contents are returned (read-first).
// Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   host_wr_valid_i/addr_i/row_i     host matrix row load (IDLE only)
//   host_start_i/flush_i/clear_i     run control
//   host_rd_valid_i/sel_i/addr_i     host readback request (IDLE/DONE only)
//   host_rd_valid_o/row_o            host readback data, 1-cycle latency
//   lu_start_o, lu_flush_o           one-cycle pulses to the engine
//   lu_in_ready_i                    engine idle
//   rd_addr_i/addr_valid_i           engine row read request (RUN only)
//   rd_row_o/addr_o/row_valid_o      engine read response, 1-cycle latency
//   wr_row_i/addr_i/valid_i, wr_ready_o        engine write-back
//   l_col_i, u_row_i, result_addr_i/valid_i, result_ready_o   result capture
//   busy_o, done_o, result_cnt_o     status
//
// state | meaning
// IDLE  | host may load M and read back; engine traffic dropped
// RUN   | engine owns M, results captured, host traffic ignored
// DONE  | results complete; host readback until host_clear_i
module lu_row_server
  import lu_row_server_pkg::*;
#(
  parameter int SIZE    = LU_SIZE,
  parameter int WIDTH   = LU_WIDTH,
  localparam int ADDR_W = addr_w(SIZE),
  localparam int ROW_W  = row_w(SIZE, WIDTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              host_wr_valid_i,
  input  logic [ADDR_W-1:0] host_wr_addr_i,
  input  logic [ROW_W-1:0]  host_wr_row_i,
  input  logic              host_start_i,
  input  logic              host_flush_i,
  input  logic              host_clear_i,
  input  logic              host_rd_valid_i,
  input  logic [1:0]        host_rd_sel_i,
  input  logic [ADDR_W-1:0] host_rd_addr_i,
  output logic              host_rd_valid_o,
  output logic [ROW_W-1:0]  host_rd_row_o,
  output logic              lu_start_o,
  output logic              lu_flush_o,
  input  logic              lu_in_ready_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic              rd_addr_valid_i,
  output logic [ROW_W-1:0]  rd_row_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              rd_row_valid_o,
  input  logic [ROW_W-1:0]  wr_row_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [ROW_W-1:0]  l_col_i,
  input  logic [ROW_W-1:0]  u_row_i,
  input  logic [ADDR_W-1:0] result_addr_i,
  input  logic              result_valid_i,
  output logic              result_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W:0]   result_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(SIZE);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

`ifdef LU_ROW_SERVER_BYPASS_EN
  localparam bit M_WRITE_FIRST = 1'b1;
`else
  localparam bit M_WRITE_FIRST = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              in_idle, in_run;

  logic              eng_rd, host_rd, host_wr, eng_wb, res_acc;
  logic              m_we, m_re;
  logic [ADDR_W-1:0] m_waddr, m_raddr;
  logic [ROW_W-1:0]  m_wdata;
  logic [ROW_W-1:0]  m_q, l_q, u_q;

  logic              lu_start_q, lu_flush_q;
  logic              rd_vld_q, host_vld_q;
  logic [ADDR_W-1:0] rd_addr_q;
  row_sel_e          host_sel_q;
  logic [ROW_W-1:0]  host_row;

  assign in_idle = (state_q == ST_IDLE);
  assign in_run  = (state_q == ST_RUN);

  // Traffic qualification: engine owns the banks in RUN, the host otherwise.
  assign eng_rd  = rd_addr_valid_i && in_run;
  assign eng_wb  = wr_valid_i && in_run;
  assign res_acc = result_valid_i && in_run;
  assign host_rd = host_rd_valid_i && !in_run;
  assign host_wr = host_wr_valid_i && in_idle;

  // M has a single read and a single write port; the two owners never overlap.
  assign m_we    = eng_wb || host_wr;
  assign m_waddr = in_run ? wr_addr_i : host_wr_addr_i;
  assign m_wdata = in_run ? wr_row_i  : host_wr_row_i;
  assign m_re    = eng_rd || host_rd;
  assign m_raddr = in_run ? rd_addr_i : host_rd_addr_i;

  lu_row_server_bank #(
    .DEPTH       (SIZE),
    .ROW_W       (ROW_W),
    .WRITE_FIRST (M_WRITE_FIRST)
  ) u_bank_m (
    .clk_i   (clk_i),
    .we_i    (m_we),
    .waddr_i (m_waddr),
    .wdata_i (m_wdata),
    .re_i    (m_re),
    .raddr_i (m_raddr),
    .rdata_o (m_q)
  );

  lu_row_server_bank #(
    .DEPTH       (SIZE),
    .ROW_W       (ROW_W),
    .WRITE_FIRST (1'b0)
  ) u_bank_l (
    .clk_i   (clk_i),
    .we_i    (res_acc),
    .waddr_i (result_addr_i),
    .wdata_i (l_col_i),
    .re_i    (host_rd),
    .raddr_i (host_rd_addr_i),
    .rdata_o (l_q)
  );

  lu_row_server_bank #(
    .DEPTH       (SIZE),
    .ROW_W       (ROW_W),
    .WRITE_FIRST (1'b0)
  ) u_bank_u (
    .clk_i   (clk_i),
    .we_i    (res_acc),
    .waddr_i (result_addr_i),
    .wdata_i (u_row_i),
    .re_i    (host_rd),
    .raddr_i (host_rd_addr_i),
    .rdata_o (u_q)
  );

  // Completion looks at the count including this cycle's handshake, so done_o
  // rises the cycle after the SIZE-th result when the engine is already idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (res_acc && (cnt_q != CNT_FULL)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    case (state_q)
      ST_IDLE: begin
        if (host_start_i) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (host_flush_i) begin
          state_d = ST_IDLE;
        end else if ((cnt_d == CNT_FULL) && lu_in_ready_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (host_clear_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      lu_start_q <= 1'b0;
      lu_flush_q <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_addr_q  <= '0;
      host_vld_q <= 1'b0;
      host_sel_q <= SEL_MAT;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lu_start_q <= in_idle && host_start_i;
      lu_flush_q <= in_run && host_flush_i;
      rd_vld_q   <= eng_rd;
      rd_addr_q  <= eng_rd ? rd_addr_i : '0;
      host_vld_q <= host_rd;
      host_sel_q <= host_rd ? row_sel_e'(host_rd_sel_i) : SEL_MAT;
    end
  end

  // Bank registers are not reset, so row outputs are gated by their valids.
  always_comb begin
    host_row = '0;
    if (host_vld_q) begin
      case (host_sel_q)
        SEL_MAT: host_row = m_q;
        SEL_L:   host_row = l_q;
        SEL_U:   host_row = u_q;
        default: host_row = '0;
      endcase
    end
  end

  assign host_rd_valid_o = host_vld_q;
  assign host_rd_row_o   = host_row;
  assign rd_row_valid_o  = rd_vld_q;
  assign rd_row_o        = rd_vld_q ? m_q : '0;
  assign rd_addr_o       = rd_addr_q;
  assign lu_start_o      = lu_start_q;
  assign lu_flush_o      = lu_flush_q;
  assign wr_ready_o      = in_run;
  assign result_ready_o  = in_run;
  assign busy_o          = in_run;
  assign done_o          = (state_q == ST_DONE);
  assign result_cnt_o    = cnt_q;

endmodule

// File: tb/tb_lu_row_server.sv
module tb_lu_row_server;
  import lu_row_server_pkg::*;

  localparam int N  = LU_SIZE;
  localparam int AW = addr_w(LU_SIZE);
  localparam int RW = row_w(LU_SIZE, LU_WIDTH);

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          host_wr_valid_i;
  logic [AW-1:0] host_wr_addr_i;
  logic [RW-1:0] host_wr_row_i;
  logic          host_start_i, host_flush_i, host_clear_i;
  logic          host_rd_valid_i;
  logic [1:0]    host_rd_sel_i;
  logic [AW-1:0] host_rd_addr_i;
  logic          host_rd_valid_o;
  logic [RW-1:0] host_rd_row_o;
  logic          lu_start_o, lu_flush_o;
  logic          lu_in_ready_i;
  logic [AW-1:0] rd_addr_i;
  logic          rd_addr_valid_i;
  logic [RW-1:0] rd_row_o;
  logic [AW-1:0] rd_addr_o;
  logic          rd_row_valid_o;
  logic [RW-1:0] wr_row_i;
  logic [AW-1:0] wr_addr_i;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [RW-1:0] l_col_i, u_row_i;
  logic [AW-1:0] result_addr_i;
  logic          result_valid_i;
  logic          result_ready_o;
  logic          busy_o, done_o;
  logic [AW:0]   result_cnt_o;

  lu_row_server dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_wr_valid_i(host_wr_valid_i), .host_wr_addr_i(host_wr_addr_i),
    .host_wr_row_i(host_wr_row_i), .host_start_i(host_start_i),
    .host_flush_i(host_flush_i), .host_clear_i(host_clear_i),
    .host_rd_valid_i(host_rd_valid_i), .host_rd_sel_i(host_rd_sel_i),
    .host_rd_addr_i(host_rd_addr_i), .host_rd_valid_o(host_rd_valid_o),
    .host_rd_row_o(host_rd_row_o), .lu_start_o(lu_start_o), .lu_flush_o(lu_flush_o),
    .lu_in_ready_i(lu_in_ready_i), .rd_addr_i(rd_addr_i),
    .rd_addr_valid_i(rd_addr_valid_i), .rd_row_o(rd_row_o), .rd_addr_o(rd_addr_o),
    .rd_row_valid_o(rd_row_valid_o), .wr_row_i(wr_row_i), .wr_addr_i(wr_addr_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .l_col_i(l_col_i),
    .u_row_i(u_row_i), .result_addr_i(result_addr_i),
    .result_valid_i(result_valid_i), .result_ready_o(result_ready_o),
    .busy_o(busy_o), .done_o(done_o), .result_cnt_o(result_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: row arrays plus a mode (0 idle, 1 running, 2 finished)
  // and the result count, advanced from the protocol rules once per cycle.
  logic [RW-1:0] mm [N];
  logic [RW-1:0] ml [N];
  logic [RW-1:0] mu [N];
  int mode = 0;
  int mcnt = 0;

  function automatic logic [63:0] fold(input logic [RW-1:0] r);
    logic [63:0] x = '0;
    for (int i = 0; i < RW/64; i++) x ^= r[i*64 +: 64];
    return x;
  endfunction

  function automatic logic [RW-1:0] rand_row();
    logic [RW-1:0] r;
    for (int i = 0; i < RW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic chk_row(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got row fold %h expected row fold %h (t=%0t)",
                  nm, fold(act), fold(exp), $time);
  endtask

  task automatic clr_in();
    rst_i = 1'b0;
    host_wr_valid_i = 1'b0; host_wr_addr_i = '0; host_wr_row_i = '0;
    host_start_i = 1'b0; host_flush_i = 1'b0; host_clear_i = 1'b0;
    host_rd_valid_i = 1'b0; host_rd_sel_i = '0; host_rd_addr_i = '0;
    lu_in_ready_i = 1'b0; rd_addr_i = '0; rd_addr_valid_i = 1'b0;
    wr_row_i = '0; wr_addr_i = '0; wr_valid_i = 1'b0;
    l_col_i = '0; u_row_i = '0; result_addr_i = '0; result_valid_i = 1'b0;
  endtask

  // One clock: predict from the current inputs, clock, compare every output.
  task automatic cyc();
    logic          erv, ehv, es, ef;
    logic [AW-1:0] ea;
    logic [RW-1:0] er, eh;
    bit            run;
    erv = 0; ehv = 0; es = 0; ef = 0; ea = '0; er = '0; eh = '0;
    if (rst_i) begin
      mode = 0;
      mcnt = 0;
    end else begin
      run = (mode == 1);
      if (run && rd_addr_valid_i) begin
        erv = 1; ea = rd_addr_i; er = mm[rd_addr_i];
`ifdef LU_ROW_SERVER_BYPASS_EN
        if (wr_valid_i && wr_addr_i == rd_addr_i) er = wr_row_i;
`endif
      end
      if (!run && host_rd_valid_i) begin
        ehv = 1;
        case (host_rd_sel_i)
          2'd0: eh = mm[host_rd_addr_i];
          2'd1: eh = ml[host_rd_addr_i];
          2'd2: eh = mu[host_rd_addr_i];
          default: eh = '0;
        endcase
      end
      es = (mode == 0) && host_start_i;
      ef = run && host_flush_i;
      if (mode == 0 && host_wr_valid_i) mm[host_wr_addr_i] = host_wr_row_i;
      if (run && wr_valid_i) mm[wr_addr_i] = wr_row_i;
      if (run && result_valid_i) begin
        ml[result_addr_i] = l_col_i;
        mu[result_addr_i] = u_row_i;
        if (mcnt < N) mcnt++;
      end
      if (mode == 0) begin
        if (host_start_i) begin mode = 1; mcnt = 0; end
      end else if (mode == 1) begin
        if (host_flush_i) mode = 0;
        else if (mcnt == N && lu_in_ready_i) mode = 2;
      end else if (host_clear_i) begin
        mode = 0;
      end
    end
    @(posedge clk_i);
    #1;
    chk("busy", 64'(busy_o), 64'(mode == 1));
    chk("done", 64'(done_o), 64'(mode == 2));
    chk("ready", 64'({wr_ready_o, result_ready_o}), 64'(mode == 1 ? 2'b11 : 2'b00));
    chk("pulses", 64'({lu_start_o, lu_flush_o}), 64'({es, ef}));
    chk("result_cnt", 64'(result_cnt_o), 64'(mcnt));
    chk("eng_rd_vld_addr", 64'({rd_row_valid_o, rd_addr_o}), 64'({erv, ea}));
    chk_row("eng_rd_row", rd_row_o, er);
    chk("host_rd_vld", 64'(host_rd_valid_o), 64'(ehv));
    chk_row("host_rd_row", host_rd_row_o, eh);
  endtask

  typedef struct {
    logic start, flush, clear, ready;
    logic e_busy, e_done, e_sp, e_fp;
  } fsm_vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks made", n_chk);
    $fatal(1);
  end

  initial begin
    fsm_vec_t      vt [12];
    logic [RW-1:0] hrow [N];
    logic [RW-1:0] uv [N];
    logic [RW-1:0] tmp, tmp2;

    vt[0]  = '{0,0,1,0, 0,0,0,0};
    vt[1]  = '{0,1,0,0, 0,0,0,0};
    vt[2]  = '{1,0,0,0, 1,0,1,0};
    vt[3]  = '{1,0,0,0, 1,0,0,0};
    vt[4]  = '{0,0,1,0, 1,0,0,0};
    vt[5]  = '{0,0,0,1, 1,0,0,0};
    vt[6]  = '{0,1,0,0, 0,0,0,1};
    vt[7]  = '{0,0,0,0, 0,0,0,0};
    vt[8]  = '{1,0,0,0, 1,0,1,0};
    vt[9]  = '{1,1,0,1, 0,0,0,1};
    vt[10] = '{1,1,0,0, 1,0,1,0};
    vt[11] = '{0,1,0,0, 0,0,0,1};

    // Reset
    clr_in(); rst_i = 1'b1;
    cyc(); cyc();
    chk("rst_busy_done", 64'({busy_o, done_o}), 64'(0));
    chk("rst_cnt", 64'(result_cnt_o), 64'(0));

    // 1: load M, start, engine read of row 5
    for (int i = 0; i < N; i++) begin
      clr_in(); host_wr_valid_i = 1; host_wr_addr_i = AW'(i);
      hrow[i] = rand_row(); host_wr_row_i = hrow[i];
      cyc();
    end
    clr_in(); host_start_i = 1; cyc();
    chk("t1_start_pulse", 64'(lu_start_o), 64'(1));
    clr_in(); rd_addr_valid_i = 1; rd_addr_i = AW'(5); cyc();
    chk("t1_rd_valid", 64'(rd_row_valid_o), 64'(1));
    chk("t1_rd_addr", 64'(rd_addr_o), 64'(5));
    chk_row("t1_rd_row", rd_row_o, hrow[5]);

    // 2: collision on row 3
    tmp = rand_row();
    clr_in(); rd_addr_valid_i = 1; rd_addr_i = AW'(3);
    wr_valid_i = 1; wr_addr_i = AW'(3); wr_row_i = tmp;
    cyc();
`ifdef LU_ROW_SERVER_BYPASS_EN
    chk_row("t2_collision_write_first", rd_row_o, tmp);
`else
    chk_row("t2_collision_read_first", rd_row_o, hrow[3]);
`endif
    clr_in(); rd_addr_valid_i = 1; rd_addr_i = AW'(3); cyc();
    chk_row("t2_after_wb", rd_row_o, tmp);

    // 3: 16 results, done, U readback
    for (int i = 0; i < N; i++) begin
      clr_in(); result_valid_i = 1; result_addr_i = AW'(i); lu_in_ready_i = 1;
      l_col_i = rand_row(); uv[i] = rand_row(); u_row_i = uv[i];
      cyc();
      if (i < N-1) chk("t3_not_done_early", 64'(done_o), 64'(0));
    end
    chk("t3_done", 64'(done_o), 64'(1));
    chk("t3_cnt_full", 64'(result_cnt_o), 64'(N));
    clr_in(); host_rd_valid_i = 1; host_rd_sel_i = 2; host_rd_addr_i = AW'(7); cyc();
    chk_row("t3_u7", host_rd_row_o, uv[7]);
    clr_in(); host_rd_valid_i = 1; host_rd_sel_i = 3; host_rd_addr_i = AW'(7); cyc();
    chk_row("t3_reserved_zero", host_rd_row_o, '0);
    clr_in(); host_start_i = 1; cyc();
    chk("t3_start_in_done", 64'({done_o, lu_start_o}), 64'(2'b10));
    clr_in(); host_clear_i = 1; cyc();
    chk("t3_cleared", 64'({busy_o, done_o}), 64'(0));

    // 4: duplicate result address
    clr_in(); host_start_i = 1; cyc();
    tmp = rand_row(); tmp2 = rand_row();
    clr_in(); result_valid_i = 1; result_addr_i = AW'(4); l_col_i = tmp; cyc();
    clr_in(); result_valid_i = 1; result_addr_i = AW'(4); l_col_i = tmp2; cyc();
    chk("t4_cnt_dup", 64'(result_cnt_o), 64'(2));
    clr_in(); host_rd_valid_i = 1; host_rd_sel_i = 1; host_rd_addr_i = AW'(4); cyc();
    chk("t4_host_rd_in_run", 64'(host_rd_valid_o), 64'(0));

    // 5: flush after 9 results
    for (int i = 0; i < 7; i++) begin
      clr_in(); result_valid_i = 1; result_addr_i = AW'(i + 8);
      l_col_i = rand_row(); u_row_i = rand_row(); cyc();
    end
    chk("t5_cnt9", 64'(result_cnt_o), 64'(9));
    clr_in(); host_flush_i = 1; cyc();
    chk("t5_flush", 64'({lu_flush_o, busy_o}), 64'(2'b10));
    clr_in(); host_rd_valid_i = 1; host_rd_sel_i = 1; host_rd_addr_i = AW'(4); cyc();
    chk("t5_flush_once_cnt", 64'({lu_flush_o, result_cnt_o}), 64'(9));
    chk_row("t4_l4_second", host_rd_row_o, tmp2);
    clr_in(); host_start_i = 1; cyc();
    chk("t5_cnt_cleared", 64'(result_cnt_o), 64'(0));

    // Saturation without completion, then completion when engine goes idle
    for (int i = 0; i < N + 1; i++) begin
      clr_in(); result_valid_i = 1; result_addr_i = AW'(i % N);
      l_col_i = rand_row(); u_row_i = rand_row(); cyc();
    end
    chk("sat_cnt", 64'({busy_o, result_cnt_o}), 64'({1'b1, (AW+1)'(N)}));
    clr_in(); lu_in_ready_i = 1; cyc();
    chk("sat_then_done", 64'(done_o), 64'(1));
    clr_in(); host_clear_i = 1; cyc();

    // 6: reset mid-RUN keeps rows written during RUN
    clr_in(); host_start_i = 1; cyc();
    tmp = rand_row();
    clr_in(); wr_valid_i = 1; wr_addr_i = AW'(10); wr_row_i = tmp; cyc();
    clr_in(); rst_i = 1; cyc();
    chk("t6_rst_flags", 64'({busy_o, done_o, lu_flush_o, lu_start_o, wr_ready_o}), 64'(0));
    chk("t6_rst_cnt", 64'(result_cnt_o), 64'(0));
    clr_in(); host_rd_valid_i = 1; host_rd_sel_i = 0; host_rd_addr_i = AW'(10); cyc();
    chk_row("t6_m_kept", host_rd_row_o, tmp);

    // Control table from IDLE
    for (int i = 0; i < 12; i++) begin
      clr_in();
      host_start_i = vt[i].start; host_flush_i = vt[i].flush;
      host_clear_i = vt[i].clear; lu_in_ready_i = vt[i].ready;
      cyc();
      chk($sformatf("fsm_vec%0d", i),
          64'({busy_o, done_o, lu_start_o, lu_flush_o}),
          64'({vt[i].e_busy, vt[i].e_done, vt[i].e_sp, vt[i].e_fp}));
    end

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      clr_in();
      if ($urandom_range(0, 99) < 2) begin
        rst_i = 1;
      end else begin
        host_start_i    = ($urandom_range(0, 19) == 0);
        host_flush_i    = ($urandom_range(0, 39) == 0);
        host_clear_i    = ($urandom_range(0, 9) == 0);
        lu_in_ready_i   = 1'($urandom);
        rd_addr_valid_i = 1'($urandom);
        rd_addr_i       = AW'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          wr_valid_i = 1;
          wr_addr_i  = ($urandom_range(0, 3) == 0) ? rd_addr_i : AW'($urandom);
          wr_row_i   = rand_row();
        end
        if ($urandom_range(0, 1) == 1) begin
          result_valid_i = 1; result_addr_i = AW'($urandom);
          l_col_i = rand_row(); u_row_i = rand_row();
        end
        if ($urandom_range(0, 9) < 3) begin
          host_wr_valid_i = 1; host_wr_addr_i = AW'($urandom); host_wr_row_i = rand_row();
        end else if ($urandom_range(0, 9) < 4) begin
          host_rd_valid_i = 1; host_rd_sel_i = 2'($urandom); host_rd_addr_i = AW'($urandom);
        end
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
